// File: rtl/ram_block_mover.sv
// Single-port RAM initiator: serves READ/WRITE requests plus block FILL and COPY.
// The RAM sees at most one access per cycle, and every mem_* output comes straight from a register.
module ram_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_COPY  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_FILL,
    S_CP_RD,
    S_CP_WR
  } state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_src, w_src_next;
  logic [ADDR_W-1:0]   r_dst, w_dst_next;
  logic [ADDR_W-1:0]   r_cnt, w_cnt_next;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_next;
  logic                r_mem_we, w_mem_we_next;
  logic                r_rsp_valid, w_rsp_valid_next;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_next;
  logic                r_done, w_done_next;

  // r_cnt holds the number of bytes still to move after the current one.
  always_comb begin
    w_state_next     = r_state;
    w_src_next       = r_src;
    w_dst_next       = r_dst;
    w_cnt_next       = r_cnt;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_mem_we_next    = 1'b0;
    w_rsp_valid_next = 1'b0;
    w_rsp_data_next  = r_rsp_data;
    w_done_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ: begin
              w_state_next    = S_RD;
              w_mem_addr_next = cmd_addr;
            end
            OP_WRITE: begin
              w_state_next     = S_WR;
              w_mem_addr_next  = cmd_addr;
              w_mem_wdata_next = cmd_data;
              w_mem_we_next    = 1'b1;
            end
            OP_FILL: begin
              if (cmd_len == '0) begin
                w_done_next = 1'b1;
              end else begin
                w_state_next     = S_FILL;
                w_mem_addr_next  = cmd_addr;
                w_mem_wdata_next = cmd_data;
                w_mem_we_next    = 1'b1;
                w_cnt_next       = cmd_len - 1'b1;
              end
            end
            OP_COPY: begin
              if (cmd_len == '0) begin
                w_done_next = 1'b1;
              end else begin
                w_state_next    = S_CP_RD;
                w_mem_addr_next = cmd_src;
                w_src_next      = cmd_src;
                w_dst_next      = cmd_addr;
                w_cnt_next      = cmd_len - 1'b1;
              end
            end
            default: w_state_next = S_IDLE;
          endcase
        end
      end
      S_RD: begin
        w_state_next     = S_IDLE;
        w_rsp_data_next  = mem_rdata;
        w_rsp_valid_next = 1'b1;
        w_done_next      = 1'b1;
      end
      S_WR: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end
      S_FILL: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_mem_addr_next = r_mem_addr + 1'b1;
          w_mem_we_next   = 1'b1;
          w_cnt_next      = r_cnt - 1'b1;
        end
      end
      S_CP_RD: begin
        // The write-data register doubles as the copy hold register.
        w_state_next     = S_CP_WR;
        w_mem_wdata_next = mem_rdata;
        w_mem_addr_next  = r_dst;
        w_mem_we_next    = 1'b1;
      end
      S_CP_WR: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next    = S_CP_RD;
          w_src_next      = r_src + 1'b1;
          w_dst_next      = r_dst + 1'b1;
          w_mem_addr_next = r_src + 1'b1;
          w_cnt_next      = r_cnt - 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_src       <= w_src_next;
      r_dst       <= w_dst_next;
      r_cnt       <= w_cnt_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_mem_we    <= w_mem_we_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
      r_done      <= w_done_next;
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign done      = r_done;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: an attached 256x8 RAM, directed cases, then random commands,
// each checked against an ordered list of expected RAM accesses and a reference memory image.
module tb_ram_block_mover;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_addr, cmd_src, cmd_len, cmd_data;
  logic       rsp_valid, done, busy, mem_we;
  logic [7:0] rsp_data, mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ram_block_mover #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_src(cmd_src), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  logic [7:0] ram [256];
  logic       ram_clr = 1'b0;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = ram[mem_addr];

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  logic [7:0] ref_mem [256];
  logic [7:0] last_rsp;
  acc_t       exp_q[$];
  int         checks = 0;
  int         passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk(tag, bad, 0);
  endtask

  // Drive a command in the current cycle (C0) and follow it to its done cycle.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] src,
                         input logic [7:0] len, input logic [7:0] data, input bit poke);
    acc_t       acc;
    logic [7:0] a, s, v, rsp_exp;
    int         n;
    exp_q.delete();
    rsp_exp = last_rsp;
    case (op)
      2'b00: begin
        acc = '{we: 1'b0, addr: addr, wdata: 8'h00}; exp_q.push_back(acc);
        rsp_exp = ref_mem[addr];
      end
      2'b01: begin
        acc = '{we: 1'b1, addr: addr, wdata: data}; exp_q.push_back(acc);
        ref_mem[addr] = data;
      end
      2'b10: begin
        for (int i = 0; i < int'(len); i++) begin
          a = addr + 8'(i);
          acc = '{we: 1'b1, addr: a, wdata: data}; exp_q.push_back(acc);
          ref_mem[a] = data;
        end
      end
      default: begin
        for (int i = 0; i < int'(len); i++) begin
          s = src + 8'(i);
          a = addr + 8'(i);
          v = ref_mem[s];
          acc = '{we: 1'b0, addr: s, wdata: 8'h00}; exp_q.push_back(acc);
          acc = '{we: 1'b1, addr: a, wdata: v}; exp_q.push_back(acc);
          ref_mem[a] = v;
        end
      end
    endcase
    n = exp_q.size();

    chk("ready_c0", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_src = src; cmd_len = len; cmd_data = data;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (k == 1) cmd_valid = 1'b0;
      if (poke && k == 2) begin
        chk("ready_busy", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = addr ^ 8'h80; cmd_data = ~data;
      end
      if (poke && k == 3) cmd_valid = 1'b0;
      if (k <= n) begin
        acc = exp_q[k-1];
        chk("busy", busy, 1);
        chk("done_early", done, 0);
        chk("rsp_valid_early", rsp_valid, 0);
        chk("mem_we", mem_we, acc.we);
        chk("mem_addr", mem_addr, acc.addr);
        if (acc.we) chk("mem_wdata", mem_wdata, acc.wdata);
      end else begin
        chk("done", done, 1);
        chk("busy_done", busy, 0);
        chk("ready_done", cmd_ready, 1);
        chk("mem_we_idle", mem_we, 0);
        chk("rsp_valid", rsp_valid, (op == 2'b00));
        chk("rsp_data", rsp_data, rsp_exp);
      end
    end
    last_rsp = rsp_exp;
    compare_mem("ram_contents");
    $display("cmd op=%0d addr=%h src=%h len=%0d data=%h accesses=%0d", op, addr, src, len, data, n);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_src = '0; cmd_len = '0; cmd_data = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    last_rsp = 8'h00;
    ram_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    ram_clr = 1'b0;
    rst_n = 1'b1;

    // WRITE then READ
    run_cmd(2'b01, 8'h10, 8'h00, 8'd0, 8'hA5, 1'b0);
    run_cmd(2'b00, 8'h10, 8'h00, 8'd0, 8'h00, 1'b0);
    // FILL straddling 0xFF and readback
    run_cmd(2'b10, 8'hFE, 8'h00, 8'd4, 8'h3C, 1'b0);
    run_cmd(2'b00, 8'hFE, 8'h00, 8'd0, 8'h00, 1'b0);
    run_cmd(2'b00, 8'hFF, 8'h00, 8'd0, 8'h00, 1'b0);
    run_cmd(2'b00, 8'h00, 8'h00, 8'd0, 8'h00, 1'b0);
    run_cmd(2'b00, 8'h01, 8'h00, 8'd0, 8'h00, 1'b0);
    // COPY 0x00..0x02 -> 0x80
    run_cmd(2'b01, 8'h00, 8'h00, 8'd0, 8'h11, 1'b0);
    run_cmd(2'b01, 8'h01, 8'h00, 8'd0, 8'h22, 1'b0);
    run_cmd(2'b01, 8'h02, 8'h00, 8'd0, 8'h33, 1'b0);
    run_cmd(2'b11, 8'h80, 8'h00, 8'd3, 8'h00, 1'b0);
    // overlapping COPY replicates forward
    run_cmd(2'b01, 8'h20, 8'h00, 8'd0, 8'h11, 1'b0);
    run_cmd(2'b11, 8'h21, 8'h20, 8'd3, 8'h00, 1'b0);
    // zero-length FILL/COPY and a request poked while busy
    run_cmd(2'b10, 8'h30, 8'h00, 8'd0, 8'h55, 1'b0);
    run_cmd(2'b11, 8'h30, 8'h40, 8'd0, 8'h00, 1'b0);
    run_cmd(2'b10, 8'h50, 8'h00, 8'd6, 8'h99, 1'b1);
    // COPY straddling 0xFF on both ranges
    run_cmd(2'b11, 8'hFD, 8'hFE, 8'd5, 8'h00, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              8'($urandom_range(0, 10)), 8'($urandom), 1'b0);
    end

    // reset after two FILL writes
    chk("ready_c0", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 8'h40; cmd_len = 8'd6; cmd_data = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("we_before_rst", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_we", mem_we, 0);
    chk("rst_async_busy", busy, 0);
    ref_mem[8'h40] = 8'h77;
    ref_mem[8'h41] = 8'h77;
    last_rsp = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    chk("ready_after_rst", cmd_ready, 1);
    compare_mem("ram_after_rst");
    $display("cmd reset during FILL addr=40 len=6 after 2 writes");
    run_cmd(2'b00, 8'h41, 8'h00, 8'd0, 8'h00, 1'b0);
    run_cmd(2'b00, 8'h42, 8'h00, 8'd0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
